// File: rtl/mbtrain_sb_msg_launcher_if.sv
// Handshake/status bundle between the MBTRAIN wrapper mux, the launcher and the sideband encoder.
// Adds o_timeout when SB_LAUNCH_TIMEOUT_EN is defined.
interface mbtrain_sb_msg_launcher_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          i_en;
  logic [3:0]    i_msg;
  logic          i_msg_valid;
  logic          i_sb_busy;
  logic [3:0]    o_sb_msg;
  logic          o_sb_req;
  logic          o_falling_edge_busy;
  logic          o_full;
  logic          o_empty;
  logic          o_overflow;
  logic [LW-1:0] o_level;
`ifdef SB_LAUNCH_TIMEOUT_EN
  logic          o_timeout;
`endif

  modport master (
    output i_en, i_msg, i_msg_valid, i_sb_busy,
    input  o_sb_msg, o_sb_req, o_falling_edge_busy, o_full, o_empty, o_overflow, o_level
`ifdef SB_LAUNCH_TIMEOUT_EN
    , input o_timeout
`endif
  );

  modport slave (
    input  i_en, i_msg, i_msg_valid, i_sb_busy,
    output o_sb_msg, o_sb_req, o_falling_edge_busy, o_full, o_empty, o_overflow, o_level
`ifdef SB_LAUNCH_TIMEOUT_EN
    , output o_timeout
`endif
  );
endinterface

// File: rtl/mbtrain_sb_msg_launcher.sv
// Buffers MBTRAIN sideband message codes and launches them one at a time over a req/busy handshake.
// Optional WAIT_HI watchdog enabled by defining SB_LAUNCH_TIMEOUT_EN.
module mbtrain_sb_msg_launcher #(
  parameter int unsigned DEPTH = 4
`ifdef SB_LAUNCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input logic                    clk,
  input logic                    rst_n,
  mbtrain_sb_msg_launcher_if.slave io_bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [PW-1:0] PtrOne  = PW'(1);
  localparam logic [LW-1:0] LvlOne  = LW'(1);
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitHi, StWaitLo} state_e;

  state_e        r_state;
  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [3:0]    r_sb_msg;
  logic          r_sb_req, r_busy_d, r_fall, r_overflow;
  logic          w_full, w_empty, w_pop, w_push_req, w_push;

`ifdef SB_LAUNCH_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_to_cnt;
  logic          r_timeout;
  assign io_bus.o_timeout = r_timeout;
`endif

  assign w_full     = (r_level == LvlFull);
  assign w_empty    = (r_level == '0);
  assign w_pop      = (r_state == StIssue);
  assign w_push_req = io_bus.i_en && io_bus.i_msg_valid && (io_bus.i_msg != 4'h0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_bus.i_msg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_d <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_busy_d <= io_bus.i_sb_busy;
      r_fall   <= io_bus.i_en && r_busy_d && !io_bus.i_sb_busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_sb_msg   <= 4'h0;
      r_sb_req   <= 1'b0;
      r_overflow <= 1'b0;
`ifdef SB_LAUNCH_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else if (!io_bus.i_en) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_sb_msg   <= 4'h0;
      r_sb_req   <= 1'b0;
      r_overflow <= 1'b0;
`ifdef SB_LAUNCH_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_sb_req <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LvlOne;
        2'b01:   r_level <= r_level - LvlOne;
        default: r_level <= r_level;
      endcase

      case (r_state)
        StIdle: begin
          if (!w_empty && !io_bus.i_sb_busy) begin
            r_state  <= StIssue;
            r_sb_req <= 1'b1;
            r_sb_msg <= r_mem[r_rd_ptr];
          end
        end
        StIssue: begin
          r_state <= StWaitHi;
`ifdef SB_LAUNCH_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end
        StWaitHi: begin
          if (io_bus.i_sb_busy) begin
            r_state <= StWaitLo;
`ifdef SB_LAUNCH_TIMEOUT_EN
          end else if (r_to_cnt == CntLast) begin
            // Encoder never acknowledged: drop the message, no retry.
            r_state   <= StIdle;
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
`endif
          end
        end
        StWaitLo: begin
          if (!io_bus.i_sb_busy) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.o_sb_msg            = r_sb_msg;
  assign io_bus.o_sb_req            = r_sb_req;
  assign io_bus.o_falling_edge_busy = r_fall;
  assign io_bus.o_full              = w_full;
  assign io_bus.o_empty             = w_empty;
  assign io_bus.o_overflow          = r_overflow;
  assign io_bus.o_level             = r_level;

endmodule

// File: tb/tb_mbtrain_sb_msg_launcher.sv
// Bench for mbtrain_sb_msg_launcher: directed cycle table, randomized run against a queue model,
// and hand sequences for mid-handshake reset (and the watchdog when SB_LAUNCH_TIMEOUT_EN is set).
module tb_mbtrain_sb_msg_launcher;
  localparam int unsigned DEPTH = 4;
`ifdef SB_LAUNCH_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbtrain_sb_msg_launcher_if #(.DEPTH(DEPTH)) bus ();

  mbtrain_sb_msg_launcher #(
    .DEPTH(DEPTH)
`ifdef SB_LAUNCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO_CYC)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [3:0] msg, input int lvl,
                         input logic full, input logic empty, input logic ovf, input logic fall);
    chk({tag, ".req"},   32'(bus.o_sb_req),            32'(req));
    chk({tag, ".msg"},   32'(bus.o_sb_msg),            32'(msg));
    chk({tag, ".level"}, 32'(bus.o_level),             32'(lvl));
    chk({tag, ".full"},  32'(bus.o_full),              32'(full));
    chk({tag, ".empty"}, 32'(bus.o_empty),             32'(empty));
    chk({tag, ".ovf"},   32'(bus.o_overflow),          32'(ovf));
    chk({tag, ".fall"},  32'(bus.o_falling_edge_busy), 32'(fall));
  endtask

  task automatic drive(input logic en, input logic v, input logic [3:0] m, input logic busy);
    bus.i_en        = en;
    bus.i_msg_valid = v;
    bus.i_msg       = m;
    bus.i_sb_busy   = busy;
  endtask

  // Directed vectors: inputs for one cycle, outputs expected in the following cycle.
  typedef struct {
    logic en; logic v; logic [3:0] m; logic busy;
    logic req; logic [3:0] msg; int lvl; logic full; logic empty; logic ovf; logic fall;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic en, input logic v, input logic [3:0] m, input logic busy,
                              input logic req, input logic [3:0] msg, input int lvl,
                              input logic full, input logic empty, input logic ovf,
                              input logic fall);
    vec_t e;
    e = '{en, v, m, busy, req, msg, lvl, full, empty, ovf, fall};
    tbl.push_back(e);
  endfunction

  // Reference model: message queue plus handshake phase tracking.
  logic [3:0] mq[$];
  logic       m_req, m_ovf, m_fall, m_busy_d, m_hs, m_hi, m_to;
  logic [3:0] m_msg;
  int         m_to_cnt;

  task automatic model_step(input logic en, input logic v, input logic [3:0] m, input logic busy);
    logic full, pop, push, nreq;
    m_fall   = en && m_busy_d && !busy;
    m_busy_d = busy;
    if (!en) begin
      mq.delete();
      m_ovf = 0; m_msg = 0; m_req = 0; m_hs = 0; m_hi = 0; m_to = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = m_req;
      push = v && (m != 4'h0);
      nreq = 1'b0;
      if (push && full && !pop) m_ovf = 1'b1;
      if (m_req) begin
        void'(mq.pop_front());
        m_hs = 1; m_hi = 0; m_to_cnt = 0;
      end else if (m_hs && !m_hi) begin
        if (busy) m_hi = 1'b1;
`ifdef SB_LAUNCH_TIMEOUT_EN
        else begin
          m_to_cnt++;
          if (m_to_cnt == TO_CYC) begin m_hs = 0; m_to = 1; end
        end
`endif
      end else if (m_hs) begin
        if (!busy) m_hs = 1'b0;
      end else if (mq.size() > 0 && !busy) begin
        nreq  = 1'b1;
        m_msg = mq[0];
      end
      if (push && (!full || pop)) mq.push_back(m);
      m_req = nreq;
    end
  endtask

  initial begin
    int   last_req, e_dly, e_hold;
    logic have_last, flushed, en, v, busy;
    logic [3:0] m;

    drive(1'b0, 1'b0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 4'h0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;

    // single message, zero code, overflow + pop/push at full, flush in WAIT_LO
    add(1,1,4'h3,0, 0,4'h0,1,0,0,0,0);
    add(1,0,4'h0,0, 1,4'h3,1,0,0,0,0);
    add(1,0,4'h0,0, 0,4'h3,0,0,1,0,0);
    add(1,0,4'h0,1, 0,4'h3,0,0,1,0,0);
    add(1,0,4'h0,1, 0,4'h3,0,0,1,0,0);
    add(1,0,4'h0,1, 0,4'h3,0,0,1,0,0);
    add(1,0,4'h0,0, 0,4'h3,0,0,1,0,1);
    add(1,0,4'h0,0, 0,4'h3,0,0,1,0,0);
    add(1,1,4'h0,0, 0,4'h3,0,0,1,0,0);
    add(1,0,4'h0,0, 0,4'h3,0,0,1,0,0);
    add(1,1,4'h1,1, 0,4'h3,1,0,0,0,0);
    add(1,1,4'h2,1, 0,4'h3,2,0,0,0,0);
    add(1,1,4'h3,1, 0,4'h3,3,0,0,0,0);
    add(1,1,4'h4,1, 0,4'h3,4,1,0,0,0);
    add(1,1,4'h5,1, 0,4'h3,4,1,0,1,0);
    add(1,0,4'h0,0, 1,4'h1,4,1,0,1,1);
    add(1,1,4'h6,0, 0,4'h1,4,1,0,1,0);
    add(1,0,4'h0,1, 0,4'h1,4,1,0,1,0);
    add(1,0,4'h0,0, 0,4'h1,4,1,0,1,1);
    add(1,0,4'h0,0, 1,4'h2,4,1,0,1,0);
    add(1,0,4'h0,0, 0,4'h2,3,0,0,1,0);
    add(1,0,4'h0,1, 0,4'h2,3,0,0,1,0);
    add(0,0,4'h0,1, 0,4'h0,0,0,1,0,0);
    add(0,0,4'h0,0, 0,4'h0,0,0,1,0,0);
    add(1,0,4'h0,0, 0,4'h0,0,0,1,0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].m, tbl[i].busy);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].msg, tbl[i].lvl, tbl[i].full,
              tbl[i].empty, tbl[i].ovf, tbl[i].fall);
    end

    // Randomized run; the encoder answers each req after a random delay.
    mq.delete();
    m_req = 0; m_ovf = 0; m_fall = 0; m_busy_d = 0; m_hs = 0; m_hi = 0; m_to = 0;
    m_msg = 4'h0; m_to_cnt = 0;
    e_dly = 0; e_hold = 0; have_last = 0; flushed = 0; last_req = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_req) begin
        e_dly  = $urandom_range(0, 3);
        e_hold = $urandom_range(1, 4);
      end
      if (e_dly > 0) begin
        busy = 1'b0; e_dly--;
      end else if (e_hold > 0) begin
        busy = 1'b1; e_hold--;
      end else begin
        busy = ($urandom_range(0, 7) == 0);
      end
      en = ($urandom_range(0, 63) != 0);
      v  = ($urandom_range(0, 2) == 0);
      m  = 4'($urandom_range(0, 15));
      if (!en) flushed = 1'b1;
      drive(en, v, m, busy);
      model_step(en, v, m, busy);
      @(negedge clk);
      chk_all("rnd", m_req, m_msg, mq.size(), mq.size() == DEPTH, mq.size() == 0, m_ovf, m_fall);
`ifdef SB_LAUNCH_TIMEOUT_EN
      chk("rnd.timeout", 32'(bus.o_timeout), 32'(m_to));
`endif
      if (bus.o_sb_req) begin
        if (have_last && !flushed) chk("req_spacing_ge4", 32'((cyc - last_req) >= 4), 32'd1);
        last_req = cyc; have_last = 1'b1; flushed = 1'b0;
      end
    end

    drive(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);

`ifdef SB_LAUNCH_TIMEOUT_EN
    drive(1'b1, 1'b1, 4'h9, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    chk("to.req", 32'(bus.o_sb_req), 32'd1);
    repeat (TO_CYC) @(negedge clk);
    chk("to.not_yet", 32'(bus.o_timeout), 32'd0);
    @(negedge clk);
    chk("to.set", 32'(bus.o_timeout), 32'd1);
    chk("to.level", 32'(bus.o_level), 32'd0);
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
`endif

    // Reset asserted while in WAIT_LO; a later busy fall must not pulse.
    drive(1'b1, 1'b1, 4'h7, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    chk("rst.level", 32'(bus.o_level), 32'd1);
    @(negedge clk);
    chk("rst.req", 32'(bus.o_sb_req), 32'd1);
    chk("rst.msg", 32'(bus.o_sb_msg), 32'd7);
    bus.i_sb_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("rst.async", 0, 4'h0, 0, 0, 1, 0, 0);
    @(negedge clk);
    bus.i_sb_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst.no_fall", 32'(bus.o_falling_edge_busy), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("rst.after", 0, 4'h0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mbtrain_sb_msg_launcher.md
Name: mbtrain_sb_msg_launcher

Overview:
- Downstream of the MBTRAIN substate wrappers (selfcal, valvref, datavref, ...).
- Accepts the muxed 4-bit sideband message code and its valid from the active wrapper, and buffers it in a small FIFO.
- Launches each code to the sideband encoder with a req/busy handshake, one message at a time.
- Generates the busy falling-edge pulse that the wrappers use to sequence their next message.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 255, cycles allowed between o_sb_req and i_sb_busy rising. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- i_en  in  1  substate enable; low = flush
- i_msg  in  4  message code from wrapper mux; 4'b0000 = no message
- i_msg_valid  in  1  one-cycle push strobe
- i_sb_busy  in  1  sideband encoder busy
- o_sb_msg  out  4  code presented to encoder
- o_sb_req  out  1  one-cycle launch pulse
- o_falling_edge_busy  out  1  one-cycle pulse on busy 1->0
- o_full  out  1  FIFO full
- o_empty  out  1  FIFO empty
- o_overflow  out  1  sticky: push dropped because FIFO was full
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: all outputs 0 except o_empty=1; FSM in IDLE; pointers 0.
- Push: on i_en && i_msg_valid && i_msg!=0.
  - i_msg_valid with i_msg==0 is ignored; no flag.
  - Push when full with no pop in the same cycle: entry dropped, o_overflow set.
  - Push and pop in the same cycle while full: both accepted, level unchanged, no overflow.
- Pointers: binary, log2(DEPTH) bits, natural wrap. Level counter is updated +1, -1, or 0. o_full = level==DEPTH; o_empty = level==0.
- busy_d is i_sb_busy registered. o_falling_edge_busy is registered: it asserts in cycle N+1 when busy_d=1 and i_sb_busy=0 were sampled in cycle N. It is active only when i_en=1.
- FSM:
  - IDLE: if !o_empty && !i_sb_busy, go to ISSUE.
  - ISSUE, one cycle:
    - Pop the head into o_sb_msg (registered).
    - Assert o_sb_req for exactly this cycle.
    - Go to WAIT_HI.
  - WAIT_HI: on i_sb_busy=1, go to WAIT_LO.
  - WAIT_LO: on i_sb_busy=0, go to IDLE.
- Latency: a push into an empty FIFO with busy low gives o_sb_req 2 cycles after the push edge (cycle 1 write/IDLE, cycle 2 ISSUE).
- o_sb_msg holds its value from ISSUE until the next ISSUE. It returns to 0 only on reset or flush.
- Back-to-back messages: after WAIT_LO->IDLE, the next ISSUE is at least one cycle later. The minimum spacing between o_sb_req pulses is 4 cycles.
- Flush (i_en=0, synchronous), applied every cycle while low:
  - FSM to IDLE; pointers and level to 0; o_sb_msg=0; o_sb_req=0; o_overflow cleared.
  - busy_d keeps tracking i_sb_busy.
- Reset mid-handshake: everything returns to reset values immediately. A subsequent busy fall from the encoder produces no o_falling_edge_busy while rst_n=0.
- i_sb_busy high while in IDLE with a non-empty FIFO: wait; no req is issued.

Optional Feature:
- Macro: SB_LAUNCH_TIMEOUT_EN.
- Enabled:
  - Adds output o_timeout (1 bit, sticky, reset 0, cleared by flush) and an 8-bit-minimum counter that runs in WAIT_HI.
  - If TIMEOUT_CYCLES cycles elapse in WAIT_HI without busy rising: set o_timeout, go to IDLE, discard the message (no retry).
- Disabled: no port, no counter; WAIT_HI waits indefinitely.

Test Plan:
- Single message: push 4'h3, busy low; encoder raises busy 2 cycles after req for 3 cycles -> o_sb_req at cycle 2 with o_sb_msg=3; o_falling_edge_busy one cycle after busy falls; o_level 1->0.
- Burst: push 1,2,3,4 on consecutive cycles -> o_full=1 after the 4th; launched in order 1,2,3,4; req spacing >=4 cycles; o_overflow=0.
- Overflow: fill 4 while busy is held high, push 4'h5 -> dropped, o_overflow=1; the next push in the same cycle as an ISSUE pop is accepted.
- Zero code: i_msg_valid with i_msg=0 -> level stays 0, no req.
- Flush: 3 entries queued, in WAIT_LO, drop i_en for 1 cycle -> level=0, o_sb_msg=0, FSM IDLE; busy fall afterwards gives no pulse while i_en=0.
- Timeout (SB_LAUNCH_TIMEOUT_EN, TIMEOUT_CYCLES=8): busy never rises -> o_timeout=1 after 8 cycles in WAIT_HI; next queued entry issues normally.
